// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column-multiplexed row sampling, whole-scan reduction and
// scan-level debounce producing a committed hex key code, press strobe and held level.
module keypad_scanner #(
   parameter int unsigned SCAN_TICKS     = 25000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned TW = $clog2(SCAN_TICKS);
   localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_t;

   col_t          col_q, col_d;
   logic [TW-1:0] tick;
   logic [3:0]    rows_s1, rows_s2;
   logic          sample;
   logic          eval_q;
   logic [1:0]    hit_cnt;
   logic [3:0]    first_code;
   logic [2:0]    col_hits;
   logic [1:0]    first_row;
   logic          found;
   logic [2:0]    acc_sum;
   logic [1:0]    hit_next;
   logic [4:0]    prev_res;
   logic [4:0]    scan_res;
   logic [4:0]    committed;
   logic [DW-1:0] stable_cnt, stable_d;
   logic          commit_key, commit_none;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      unique case ({row, col})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign sample = (tick == TW'(SCAN_TICKS - 1));

   always_comb begin
      col_d = col_q;
      if (sample) begin
         unique case (col_q)
            COL0:    col_d = COL1;
            COL1:    col_d = COL2;
            COL2:    col_d = COL3;
            default: col_d = COL0;
         endcase
      end
      cols        = '1;
      cols[col_q] = 1'b0;
   end

   // Hits in the current column, first pressed row in top-to-bottom order.
   always_comb begin
      col_hits  = '0;
      first_row = '0;
      found     = 1'b0;
      for (int unsigned r = 0; r < 4; r++) begin
         if (!rows_s2[r]) begin
            col_hits = col_hits + 3'd1;
            if (!found) begin
               first_row = 2'(r);
               found     = 1'b1;
            end
         end
      end
      acc_sum  = {1'b0, hit_cnt} + col_hits;
      hit_next = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
   end

   // Results are {is_key, code}; NONE is all zero so it compares cleanly.
   always_comb begin
      scan_res    = (hit_cnt == 2'd1) ? {1'b1, first_code} : '0;
      committed   = key_held ? {1'b1, key_code} : '0;
      stable_d    = DW'(1);
      commit_key  = 1'b0;
      commit_none = 1'b0;
      if (scan_res == prev_res) begin
         stable_d = (stable_cnt == DW'(DEBOUNCE_SCANS)) ? stable_cnt : stable_cnt + DW'(1);
      end
      if (eval_q && stable_d == DW'(DEBOUNCE_SCANS) && scan_res != committed) begin
         commit_key  = scan_res[4];
         commit_none = !scan_res[4];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_s1    <= '1;
         rows_s2    <= '1;
         tick       <= '0;
         col_q      <= COL0;
         eval_q     <= 1'b0;
         hit_cnt    <= '0;
         first_code <= '0;
         prev_res   <= '0;
         stable_cnt <= '0;
         key_code   <= '0;
         key_valid  <= 1'b0;
         key_held   <= 1'b0;
      end else begin
         rows_s1   <= rows;
         rows_s2   <= rows_s1;
         tick      <= sample ? '0 : tick + TW'(1);
         col_q     <= col_d;
         eval_q    <= sample && (col_q == COL3);
         key_valid <= commit_key;
         if (sample) begin
            if (hit_cnt == 2'd0 && col_hits != 3'd0) begin
               first_code <= key_map(first_row, col_q);
            end
            hit_cnt <= hit_next;
         end
         if (eval_q) begin
            hit_cnt    <= '0;
            first_code <= '0;
            prev_res   <= scan_res;
            stable_cnt <= stable_d;
            if (commit_key) begin
               key_code <= scan_res[3:0];
               key_held <= 1'b1;
            end
            if (commit_none) begin
               key_held <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad contact model and scan-aligned
// timing checks (SCAN_TICKS=8, DEBOUNCE_SCANS=3, one scan = 32 cycles).
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c is closed
   int checks = 0;
   int errors = 0;
   int strobes = 0;
   bit prev_valid = 1'b0;
   bit rst_d = 1'b0;
   bit consec = 1'b0;
   bit near_rst = 1'b0;

   localparam logic [15:0] K1 = 16'h0001;
   localparam logic [15:0] K2 = 16'h0002;
   localparam logic [15:0] KA = 16'h0008;
   localparam logic [15:0] K5 = 16'h0020;
   localparam logic [15:0] K7 = 16'h0100;
   localparam logic [15:0] K0 = 16'h1000;
   localparam logic [15:0] KD = 16'h8000;

   keypad_scanner #(.SCAN_TICKS(8), .DEBOUNCE_SCANS(3)) dut (
      .clk(clk), .reset(reset), .rows(rows), .cols(cols),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // A closed key pulls its row low while its column is driven low.
   always_comb begin
      rows = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   always @(posedge clk) begin
      if (key_valid === 1'b1) begin
         strobes <= strobes + 1;
         if (prev_valid) consec <= 1'b1;
         if (reset || rst_d) near_rst <= 1'b1;
      end
      prev_valid <= (key_valid === 1'b1);
      rst_d      <= reset;
   end

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkn(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Stops on the first negedge where column 0 is driven after column 3.
   task automatic to_scan_start();
      logic [3:0] prev;
      bit found;
      prev  = cols;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (prev == 4'b0111 && cols == 4'b1110) found = 1'b1;
         prev = cols;
      end
      checkn("scan_align", int'(found), 1);
   endtask

   initial begin
      logic [3:0] e;
      logic [3:0] one;
      one = 4'b0001;

      wait_neg(3);
      check4("rst_cols", cols, 4'b1110);
      check4("rst_code", key_code, 4'h0);
      check4("rst_valid", {3'b0, key_valid}, 4'h0);
      check4("rst_held", {3'b0, key_held}, 4'h0);
      reset = 1'b0;

      // 1: idle column sweep
      for (int k = 0; k < 64; k++) begin
         e = ~(one << ((k / 8) % 4));
         check4("idle_cols", cols, e);
         check4("idle_valid", {3'b0, key_valid}, 4'h0);
         check4("idle_held", {3'b0, key_held}, 4'h0);
         wait_neg(1);
      end
      checkn("idle_strobes", strobes, 0);

      // 2: steady "5"
      to_scan_start();
      keys = K5;
      wait_neg(96);
      check4("k5_early", {3'b0, key_valid}, 4'h0);
      wait_neg(1);
      check4("k5_valid", {3'b0, key_valid}, 4'h1);
      check4("k5_code", key_code, 4'h5);
      check4("k5_held", {3'b0, key_held}, 4'h1);
      wait_neg(1);
      check4("k5_one_cycle", {3'b0, key_valid}, 4'h0);
      wait_neg(160);
      checkn("k5_strobes", strobes, 1);
      check4("k5_still_held", {3'b0, key_held}, 4'h1);
      to_scan_start();
      keys = '0;
      wait_neg(96);
      check4("k5_rel_early", {3'b0, key_held}, 4'h1);
      wait_neg(1);
      check4("k5_rel_held", {3'b0, key_held}, 4'h0);
      check4("k5_rel_code", key_code, 4'h5);
      check4("k5_rel_valid", {3'b0, key_valid}, 4'h0);

      // 3: bouncing "D"
      to_scan_start();
      for (int s = 0; s < 4; s++) begin
         keys = (s % 2 == 0) ? KD : 16'h0000;
         wait_neg(32);
      end
      keys = KD;
      wait_neg(96);
      check4("kd_early", {3'b0, key_valid}, 4'h0);
      checkn("kd_bounce_strobes", strobes, 1);
      check4("kd_bounce_held", {3'b0, key_held}, 4'h0);
      wait_neg(1);
      check4("kd_valid", {3'b0, key_valid}, 4'h1);
      check4("kd_code", key_code, 4'hD);
      to_scan_start();
      keys = '0;
      wait_neg(97);
      check4("kd_rel_held", {3'b0, key_held}, 4'h0);

      // 4: "1"+"2" together, then release "2"
      to_scan_start();
      keys = K1 | K2;
      wait_neg(160);
      checkn("multi_strobes", strobes, 2);
      check4("multi_held", {3'b0, key_held}, 4'h0);
      check4("multi_code", key_code, 4'hD);
      to_scan_start();
      keys = K1;
      wait_neg(96);
      check4("k1_early", {3'b0, key_valid}, 4'h0);
      wait_neg(1);
      check4("k1_valid", {3'b0, key_valid}, 4'h1);
      check4("k1_code", key_code, 4'h1);
      to_scan_start();
      keys = '0;
      wait_neg(97);
      check4("k1_rel_held", {3'b0, key_held}, 4'h0);

      // 5: "A" then straight to "0"
      to_scan_start();
      keys = KA;
      wait_neg(97);
      check4("ka_valid", {3'b0, key_valid}, 4'h1);
      check4("ka_code", key_code, 4'hA);
      to_scan_start();
      keys = K0;
      wait_neg(96);
      check4("k0_early_valid", {3'b0, key_valid}, 4'h0);
      check4("k0_early_code", key_code, 4'hA);
      check4("k0_early_held", {3'b0, key_held}, 4'h1);
      wait_neg(1);
      check4("k0_valid", {3'b0, key_valid}, 4'h1);
      check4("k0_code", key_code, 4'h0);
      check4("k0_held", {3'b0, key_held}, 4'h1);
      wait_neg(2);
      checkn("k0_strobes", strobes, 5);

      // 6: "7" committed, reset mid-scan while still held
      to_scan_start();
      keys = K7;
      wait_neg(97);
      check4("k7_valid", {3'b0, key_valid}, 4'h1);
      check4("k7_code", key_code, 4'h7);
      wait_neg(40);
      reset = 1'b1;
      wait_neg(2);
      check4("mid_rst_code", key_code, 4'h0);
      check4("mid_rst_held", {3'b0, key_held}, 4'h0);
      check4("mid_rst_valid", {3'b0, key_valid}, 4'h0);
      check4("mid_rst_cols", cols, 4'b1110);
      reset = 1'b0;
      wait_neg(1);
      check4("post_rst_cols", cols, 4'b1110);
      check4("post_rst_valid", {3'b0, key_valid}, 4'h0);
      wait_neg(95);
      check4("k7r_early", {3'b0, key_valid}, 4'h0);
      check4("k7r_early_held", {3'b0, key_held}, 4'h0);
      wait_neg(1);
      check4("k7r_valid", {3'b0, key_valid}, 4'h1);
      check4("k7r_code", key_code, 4'h7);
      check4("k7r_held", {3'b0, key_held}, 4'h1);
      wait_neg(2);
      checkn("final_strobes", strobes, 7);
      checkn("no_back_to_back", int'(consec), 0);
      checkn("no_valid_near_reset", int'(near_rst), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
